// File: rtl/gcd_iter_unit.sv
// Iterative GCD engine: one operand pair per val/rdy transaction, one swap/subtract
// step per clock, result returned with a saturating count of calculation cycles.
module gcd_iter_unit #(
  parameter int W     = 16,
  parameter int FAST  = 0,
  parameter int CNT_W = W + 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_val,
  output logic             req_rdy,
  input  logic [W-1:0]     req_a,
  input  logic [W-1:0]     req_b,
  output logic             resp_val,
  input  logic             resp_rdy,
  output logic [W-1:0]     resp_result,
  output logic [CNT_W-1:0] resp_cycles,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where val and rdy are both high.
  // req_rdy and resp_val depend only on the state register, so neither side can
  // form a combinational loop through this unit.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_nx;
  logic [W-1:0]     a_q, b_q, a_nx, b_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_nx;
      a_q   <= a_nx;
      b_q   <= b_nx;
      cnt_q <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    a_nx     = a_q;
    b_nx     = b_q;
    cnt_nx   = cnt_q;
    case (state)
      IDLE: begin
        if (req_val) begin
          a_nx     = req_a;
          b_nx     = req_b;
          cnt_nx   = '0;
          state_nx = CALC;
        end
      end
      CALC: begin
        // The termination cycle is counted too.
        cnt_nx = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        if (a_q < b_q) begin
          a_nx = (FAST != 0) ? (b_q - a_q) : b_q;
          b_nx = a_q;
        end else if (b_q != '0) begin
          a_nx = a_q - b_q;
        end else begin
          state_nx = DONE;
        end
      end
      DONE: begin
        if (resp_rdy) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign req_rdy     = (state == IDLE);
  assign resp_val    = (state == DONE);
  assign busy        = (state != IDLE);
  assign resp_result = a_q;
  assign resp_cycles = cnt_q;
  assign dbg_state   = state;

endmodule

// File: tb/tb_gcd_iter_unit.sv
// Bench for gcd_iter_unit: three instances (W=16 FAST=0, W=16 FAST=1, W=4 CNT_W=3)
// driven by directed steps, with results checked from an expected queue.
module tb_gcd_iter_unit;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_q[$];
  logic [17:0] exp_c_q[$];
  bit          chk_c_q[$];

  // Instance 0: W=16, FAST=0
  logic        req_val0, resp_rdy0, req_rdy0, resp_val0, busy0;
  logic [15:0] req_a0, req_b0, res0;
  logic [17:0] cyc0;
  logic [1:0]  st0;
  // Instance 1: W=16, FAST=1
  logic        req_val1, resp_rdy1, req_rdy1, resp_val1, busy1;
  logic [15:0] req_a1, req_b1, res1;
  logic [17:0] cyc1;
  logic [1:0]  st1;
  // Instance 2: W=4, CNT_W=3
  logic        req_val2, resp_rdy2, req_rdy2, resp_val2, busy2;
  logic [3:0]  req_a2, req_b2, res2;
  logic [2:0]  cyc2;
  logic [1:0]  st2;

  gcd_iter_unit #(.W(16), .FAST(0)) u0 (
    .clk(clk), .reset_n(reset_n), .req_val(req_val0), .req_rdy(req_rdy0),
    .req_a(req_a0), .req_b(req_b0), .resp_val(resp_val0), .resp_rdy(resp_rdy0),
    .resp_result(res0), .resp_cycles(cyc0), .busy(busy0), .dbg_state(st0));

  gcd_iter_unit #(.W(16), .FAST(1)) u1 (
    .clk(clk), .reset_n(reset_n), .req_val(req_val1), .req_rdy(req_rdy1),
    .req_a(req_a1), .req_b(req_b1), .resp_val(resp_val1), .resp_rdy(resp_rdy1),
    .resp_result(res1), .resp_cycles(cyc1), .busy(busy1), .dbg_state(st1));

  gcd_iter_unit #(.W(4), .FAST(0), .CNT_W(3)) u2 (
    .clk(clk), .reset_n(reset_n), .req_val(req_val2), .req_rdy(req_rdy2),
    .req_a(req_a2), .req_b(req_b2), .resp_val(resp_val2), .resp_rdy(resp_rdy2),
    .resp_result(res2), .resp_cycles(cyc2), .busy(busy2), .dbg_state(st2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] get_rdy(input int sel);
    case (sel)
      0: return {31'b0, req_rdy0};
      1: return {31'b0, req_rdy1};
      default: return {31'b0, req_rdy2};
    endcase
  endfunction

  function automatic logic [31:0] get_rval(input int sel);
    case (sel)
      0: return {31'b0, resp_val0};
      1: return {31'b0, resp_val1};
      default: return {31'b0, resp_val2};
    endcase
  endfunction

  function automatic logic [31:0] get_busy(input int sel);
    case (sel)
      0: return {31'b0, busy0};
      1: return {31'b0, busy1};
      default: return {31'b0, busy2};
    endcase
  endfunction

  function automatic logic [31:0] get_res(input int sel);
    case (sel)
      0: return {16'b0, res0};
      1: return {16'b0, res1};
      default: return {28'b0, res2};
    endcase
  endfunction

  function automatic logic [31:0] get_cyc(input int sel);
    case (sel)
      0: return {14'b0, cyc0};
      1: return {14'b0, cyc1};
      default: return {29'b0, cyc2};
    endcase
  endfunction

  task automatic drive_req(input int sel, input logic v, input logic [15:0] a, input logic [15:0] b);
    case (sel)
      0: begin req_val0 = v; req_a0 = a; req_b0 = b; end
      1: begin req_val1 = v; req_a1 = a; req_b1 = b; end
      default: begin req_val2 = v; req_a2 = a[3:0]; req_b2 = b[3:0]; end
    endcase
  endtask

  task automatic drive_rdy(input int sel, input logic v);
    case (sel)
      0: resp_rdy0 = v;
      1: resp_rdy1 = v;
      default: resp_rdy2 = v;
    endcase
  endtask

  function automatic logic [15:0] ref_gcd(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y, t;
    x = a; y = b;
    while (y != 16'd0) begin
      t = x % y; x = y; y = t;
    end
    return x;
  endfunction

  task automatic start_txn(input int sel, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] exp_r, input logic [17:0] exp_c, input bit chk_c);
    int n;
    n = 0;
    while (get_rdy(sel) !== 32'd1 && n < 100) begin @(negedge clk); n++; end
    chk("req_rdy_before_req", get_rdy(sel), 32'd1);
    drive_req(sel, 1'b1, a, b);
    exp_q.push_back(exp_r);
    exp_c_q.push_back(exp_c);
    chk_c_q.push_back(chk_c);
    @(negedge clk);
    drive_req(sel, 1'b0, 16'd0, 16'd0);
    chk("busy_after_accept", get_busy(sel), 32'd1);
  endtask

  // hold > 0 keeps resp_rdy low that many cycles while a stray request is offered.
  task automatic finish_txn(input int sel, input int hold);
    int n;
    logic [15:0] er;
    logic [17:0] ec;
    bit cc;
    logic [31:0] r0, c0;
    bit stable;
    n = 0;
    while (get_rval(sel) !== 32'd1 && n < 5000) begin @(negedge clk); n++; end
    chk("resp_val_seen", get_rval(sel), 32'd1);
    er = exp_q.pop_front();
    ec = exp_c_q.pop_front();
    cc = chk_c_q.pop_front();
    chk("resp_result", get_res(sel), {16'b0, er});
    if (cc) chk("resp_cycles", get_cyc(sel), {14'b0, ec});
    if (hold > 0) begin
      r0 = get_res(sel);
      c0 = get_cyc(sel);
      stable = 1'b1;
      drive_req(sel, 1'b1, 16'd100, 16'd50);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (get_res(sel) !== r0 || get_cyc(sel) !== c0 || get_rval(sel) !== 32'd1 ||
            get_rdy(sel) !== 32'd0)
          stable = 1'b0;
      end
      chk("backpressure_stable", {31'b0, stable}, 32'd1);
    end
    drive_rdy(sel, 1'b1);
    @(negedge clk);
    drive_rdy(sel, 1'b0);
    drive_req(sel, 1'b0, 16'd0, 16'd0);
    chk("idle_after_handshake", get_rdy(sel), 32'd1);
    chk("resp_val_drop", get_rval(sel), 32'd0);
  endtask

  initial begin
    logic [15:0] ra, rb;
    bit saw;
    reset_n = 1'b0;
    drive_req(0, 1'b0, 16'd0, 16'd0); drive_rdy(0, 1'b0);
    drive_req(1, 1'b0, 16'd0, 16'd0); drive_rdy(1, 1'b0);
    drive_req(2, 1'b0, 16'd0, 16'd0); drive_rdy(2, 1'b0);
    #1;
    chk("rst_resp_val", {31'b0, resp_val0}, 32'd0);
    chk("rst_busy", {31'b0, busy0}, 32'd0);
    chk("rst_result", {16'b0, res0}, 32'd0);
    chk("rst_cycles", {14'b0, cyc0}, 32'd0);
    chk("rst_state", {30'b0, st0}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_release", {31'b0, req_rdy0}, 32'd1);

    // Directed FAST=0 cases, including zero operands
    start_txn(0, 16'd12, 16'd8, 16'd4, 18'd6, 1'b1);  finish_txn(0, 0);
    start_txn(0, 16'd27, 16'd15, 16'd3, 18'd10, 1'b1); finish_txn(0, 20);
    start_txn(0, 16'd0, 16'd0, 16'd0, 18'd1, 1'b1);   finish_txn(0, 0);
    start_txn(0, 16'd5, 16'd0, 16'd5, 18'd1, 1'b1);   finish_txn(0, 0);
    start_txn(0, 16'd0, 16'd7, 16'd7, 18'd2, 1'b1);   finish_txn(0, 0);
    start_txn(0, 16'd1, 16'd1, 16'd1, 18'd3, 1'b1);   finish_txn(0, 0);

    // FAST=1 directed cases
    start_txn(1, 16'd12, 16'd8, 16'd4, 18'd5, 1'b1);  finish_txn(1, 0);
    start_txn(1, 16'd0, 16'd7, 16'd7, 18'd2, 1'b1);   finish_txn(1, 0);

    // Random pairs against a modulo-based reference
    for (int i = 0; i < 16; i++) begin
      ra = 16'($urandom_range(0, 600));
      rb = 16'($urandom_range(1, 600));
      if (i % 5 == 4) rb = 16'd0;
      start_txn(i % 2, ra, rb, ref_gcd(ra, rb), 18'd0, 1'b0);
      finish_txn(i % 2, 0);
    end

    // Reset mid-calculation aborts the transaction
    start_txn(0, 16'd65535, 16'd1, 16'd0, 18'd0, 1'b0);
    void'(exp_q.pop_back()); void'(exp_c_q.pop_back()); void'(chk_c_q.pop_back());
    repeat (5) @(negedge clk);
    chk("busy_mid_calc", {31'b0, busy0}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_resp_val", {31'b0, resp_val0}, 32'd0);
    chk("abort_busy", {31'b0, busy0}, 32'd0);
    chk("abort_result", {16'b0, res0}, 32'd0);
    chk("abort_cycles", {14'b0, cyc0}, 32'd0);
    chk("abort_state", {30'b0, st0}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (resp_val0 !== 1'b0 || busy0 !== 1'b0) saw = 1'b1;
    end
    chk("no_resp_after_abort", {31'b0, saw}, 32'd0);
    start_txn(0, 16'd9, 16'd6, 16'd3, 18'd6, 1'b1);   finish_txn(0, 0);

    // Narrow instance: counter saturates at 7
    start_txn(2, 16'd15, 16'd1, 16'd1, 18'd7, 1'b1);  finish_txn(2, 0);
    start_txn(2, 16'd6, 16'd4, 16'd2, 18'd6, 1'b1);   finish_txn(2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
